// File: rtl/sdram_rw_arb_pkg.sv
// Shared types and defaults for the camera/VGA SDRAM burst arbiter.
package sdram_rw_arb_pkg;

  localparam int unsigned ADDR_W          = 22;
  localparam int unsigned FILL_W          = 11;
  localparam int unsigned BURST_LEN_DEF   = 256;
  localparam int unsigned FRAME_WORDS_DEF = 307200;
  localparam int unsigned FB_BASE_DEF     = 0;
  localparam int unsigned WR_MIN_DEF      = 256;
  localparam int unsigned RD_THRESH_DEF   = 1024;
  localparam int unsigned RD_URGENT_DEF   = 256;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // Frame-buffer address, wrapping naturally modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] base,
                                                input logic [ADDR_W-1:0] ptr);
    return base + ptr;
  endfunction

endpackage

// File: rtl/sdram_rw_arb_if.sv
// Bundle of FIFO levels, frame restarts and the SDRAM controller handshake.
interface sdram_rw_arb_if;
  import sdram_rw_arb_pkg::*;

  logic              init_done;
  logic [FILL_W-1:0] wr_fifo_used;
  logic [FILL_W-1:0] rd_fifo_used;
  logic              frame_sync_wr;
  logic              fifo_clear;
  logic              sdram_ack;
  logic              sdram_done;
  logic              sdram_req;
  logic              sdram_wr;
  logic [ADDR_W-1:0] sdram_addr;
  logic              busy;

  modport master (
    input  init_done, wr_fifo_used, rd_fifo_used, frame_sync_wr, fifo_clear,
           sdram_ack, sdram_done,
    output sdram_req, sdram_wr, sdram_addr, busy
  );

  modport slave (
    output init_done, wr_fifo_used, rd_fifo_used, frame_sync_wr, fifo_clear,
           sdram_ack, sdram_done,
    input  sdram_req, sdram_wr, sdram_addr, busy
  );

endinterface

// File: rtl/sdram_burst_ptr.sv
// One side's burst pointer: advance on its own burst completion, wrap at the
// frame end, and defer frame restarts that arrive while the arbiter is busy.
module sdram_burst_ptr
  import sdram_rw_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              idle_i,
  input  logic              done_i,
  input  logic              own_i,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W:0]   sum_s;

  // Next pointer; any done is the return to IDLE, so a pending restart lands
  // there whether the finished burst was ours or the other side's.
  always_comb begin
    ptr_d  = ptr_q;
    pend_d = pend_q;
    sum_s  = {1'b0, ptr_q} + SUM_W'(BURST_LEN);
    if (done_i) begin
      if (restart_i || pend_q) begin
        ptr_d = {ADDR_W{1'b0}};
      end else if (own_i) begin
        ptr_d = (sum_s >= SUM_W'(FRAME_WORDS)) ? {ADDR_W{1'b0}} : sum_s[ADDR_W-1:0];
      end else begin
        ptr_d = ptr_q;
      end
      pend_d = 1'b0;
    end else if (idle_i) begin
      if (restart_i || pend_q) begin
        ptr_d = {ADDR_W{1'b0}};
      end else begin
        ptr_d = ptr_q;
      end
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q || restart_i;
    end
  end

  // Pointer and pending-restart registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q  <= {ADDR_W{1'b0}};
      pend_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sdram_rw_arb.sv
// Arbitrates SDRAM bursts between the camera write FIFO and the VGA read FIFO,
// with urgent-read priority and round-robin on ties.
module sdram_rw_arb
  import sdram_rw_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned FB_BASE     = FB_BASE_DEF,
  parameter int unsigned WR_MIN      = WR_MIN_DEF,
  parameter int unsigned RD_THRESH   = RD_THRESH_DEF,
  parameter int unsigned RD_URGENT   = RD_URGENT_DEF
) (
  input  logic           clk_133M_i,
  input  logic           rst_133i,
  sdram_rw_arb_if.master bus
);

  arb_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_ptr_s, wr_ptr_s;
  logic              rd_elig_s, rd_urgent_s, wr_elig_s, grant_wr_s;
  logic              done_s, idle_s;

  assign idle_s = (state_q == ST_IDLE);
  assign done_s = (state_q == ST_WAIT_DONE) && bus.sdram_done;

  // Eligibility and grant choice.
  always_comb begin
    rd_elig_s   = bus.init_done && (32'(bus.rd_fifo_used) < RD_THRESH);
    rd_urgent_s = bus.init_done && (32'(bus.rd_fifo_used) < RD_URGENT);
    wr_elig_s   = bus.init_done && (32'(bus.wr_fifo_used) >= WR_MIN);
    if (rd_urgent_s) begin
      grant_wr_s = 1'b0;
    end else if (rd_elig_s && wr_elig_s) begin
      grant_wr_s = !last_wr_q;
    end else begin
      grant_wr_s = wr_elig_s;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_elig_s || wr_elig_s) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          wr_d    = grant_wr_s;
          addr_d  = fb_addr(ADDR_W'(FB_BASE), grant_wr_s ? wr_ptr_s : rd_ptr_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.sdram_ack) begin
          state_d = ST_WAIT_DONE;
          req_d   = 1'b0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.sdram_done) begin
          state_d   = ST_IDLE;
          last_wr_d = wr_q;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; last_grant resets to write so a tie reads first.
  always_ff @(posedge clk_133M_i) begin
    if (!rst_133i) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      busy_q    <= 1'b0;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      last_wr_q <= last_wr_d;
    end
  end

  sdram_burst_ptr #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_rd_ptr (
    .clk_i    (clk_133M_i),
    .rst_ni   (rst_133i),
    .idle_i   (idle_s),
    .done_i   (done_s),
    .own_i    (!wr_q),
    .restart_i(bus.fifo_clear),
    .ptr_o    (rd_ptr_s)
  );

  sdram_burst_ptr #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_wr_ptr (
    .clk_i    (clk_133M_i),
    .rst_ni   (rst_133i),
    .idle_i   (idle_s),
    .done_i   (done_s),
    .own_i    (wr_q),
    .restart_i(bus.frame_sync_wr),
    .ptr_o    (wr_ptr_s)
  );

  assign bus.sdram_req  = req_q;
  assign bus.sdram_wr   = wr_q;
  assign bus.sdram_addr = addr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sdram_rw_arb.sv
// Self-checking bench for sdram_rw_arb: table of grants plus hand sequences
// for restarts, reset mid-burst and frame wrap.
module tb_sdram_rw_arb;
  import sdram_rw_arb_pkg::*;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  typedef struct {
    logic [FILL_W-1:0] rdu;
    logic [FILL_W-1:0] wru;
    logic              exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    int                ack_dly;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  vec_t tbl[13];

  sdram_rw_arb_if bus();

  sdram_rw_arb dut (
    .clk_133M_i(clk),
    .rst_133i  (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic park();
    bus.rd_fifo_used = 11'd2047;
    bus.wr_fifo_used = 11'd0;
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.sdram_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=no_req expected=req");
    end
  endtask

  // Drive fill levels, expect one grant, then ack (optionally late) and done.
  task automatic run_burst(input logic [FILL_W-1:0] rdu, input logic [FILL_W-1:0] wru,
                           input logic exp_wr, input logic [ADDR_W-1:0] exp_addr,
                           input int ack_dly, input bit clr_mid);
    exp_t e;
    bit   seen;
    bit   stable;
    @(negedge clk);
    bus.rd_fifo_used = rdu;
    bus.wr_fifo_used = wru;
    sb_q.push_back({exp_wr, exp_addr});
    wait_req(seen);
    e = sb_q.pop_front();
    if (seen) begin
      check("grant_wr", 32'(bus.sdram_wr), 32'(e.wr));
      check("grant_addr", 32'(bus.sdram_addr), 32'(e.addr));
      park();
      stable = 1'b1;
      for (int i = 0; i < ack_dly; i++) begin
        bus.sdram_done = (i == 2);
        @(negedge clk);
        if (bus.sdram_req !== 1'b1 || bus.sdram_wr !== e.wr || bus.sdram_addr !== e.addr)
          stable = 1'b0;
      end
      bus.sdram_done = 1'b0;
      if (ack_dly > 0) check("hold_stable", 32'(stable), 32'd1);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0;
      check("req_drop", 32'(bus.sdram_req), 32'd0);
      if (clr_mid) begin
        bus.fifo_clear    = 1'b1;
        bus.frame_sync_wr = 1'b1;
        @(negedge clk);
        bus.fifo_clear    = 1'b0;
        bus.frame_sync_wr = 1'b0;
      end
      @(negedge clk);
      bus.sdram_done = 1'b1;
      @(negedge clk);
      bus.sdram_done = 1'b0;
      check("idle_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    bit   seen;
    checks = 0;
    errors = 0;
    // rd, wr, expect write?, expect addr, ack delay
    tbl[0]  = '{11'd800,  11'd300, 1'b0, 22'd0,    0};
    tbl[1]  = '{11'd800,  11'd300, 1'b1, 22'd0,    0};
    tbl[2]  = '{11'd800,  11'd300, 1'b0, 22'd256,  10};
    tbl[3]  = '{11'd800,  11'd300, 1'b1, 22'd256,  0};
    tbl[4]  = '{11'd200,  11'd300, 1'b0, 22'd512,  0};
    tbl[5]  = '{11'd200,  11'd300, 1'b0, 22'd768,  0};
    tbl[6]  = '{11'd100,  11'd0,   1'b0, 22'd1024, 0};
    tbl[7]  = '{11'd2047, 11'd300, 1'b1, 22'd512,  0};
    tbl[8]  = '{11'd1023, 11'd255, 1'b0, 22'd1280, 0};
    tbl[9]  = '{11'd1024, 11'd256, 1'b1, 22'd768,  0};
    tbl[10] = '{11'd255,  11'd256, 1'b0, 22'd1536, 0};
    tbl[11] = '{11'd256,  11'd256, 1'b1, 22'd1024, 0};
    tbl[12] = '{11'd256,  11'd256, 1'b0, 22'd1792, 0};

    rst_n = 1'b0;
    bus.init_done = 1'b0;
    bus.frame_sync_wr = 1'b0;
    bus.fifo_clear = 1'b0;
    bus.sdram_ack = 1'b0;
    bus.sdram_done = 1'b0;
    park();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_req", 32'(bus.sdram_req), 32'd0);
    check("rst_wr", 32'(bus.sdram_wr), 32'd0);
    check("rst_addr", 32'(bus.sdram_addr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    bus.rd_fifo_used = 11'd100;
    repeat (5) @(negedge clk);
    check("no_init_req", 32'(bus.sdram_req), 32'd0);
    park();
    bus.init_done = 1'b1;

    for (int i = 0; i < 13; i++)
      run_burst(tbl[i].rdu, tbl[i].wru, tbl[i].exp_wr, tbl[i].exp_addr, tbl[i].ack_dly, 1'b0);

    // Restarts mid read burst: read restarts at done, write on IDLE entry.
    run_burst(11'd100, 11'd0, 1'b0, 22'd2048, 0, 1'b1);
    run_burst(11'd100, 11'd0, 1'b0, 22'd0, 0, 1'b0);
    run_burst(11'd2047, 11'd300, 1'b1, 22'd0, 0, 1'b0);

    // Stray ack/done while idle.
    @(negedge clk);
    bus.sdram_ack = 1'b1;
    bus.sdram_done = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.sdram_done = 1'b0;
    @(negedge clk);
    check("stray_busy", 32'(bus.busy), 32'd0);
    check("stray_req", 32'(bus.sdram_req), 32'd0);

    // fifo_clear in IDLE zeroes rd_ptr (was 256).
    bus.fifo_clear = 1'b1;
    @(negedge clk);
    bus.fifo_clear = 1'b0;
    run_burst(11'd100, 11'd0, 1'b0, 22'd0, 0, 1'b0);

    // Reset while waiting for done.
    @(negedge clk);
    bus.rd_fifo_used = 11'd100;
    bus.wr_fifo_used = 11'd0;
    sb_q.push_back({1'b0, 22'd256});
    wait_req(seen);
    e = sb_q.pop_front();
    if (seen) begin
      check("pre_rst_addr", 32'(bus.sdram_addr), 32'(e.addr));
      park();
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0;
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      bus.sdram_done = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      bus.sdram_done = 1'b0;
      check("mid_rst_req", 32'(bus.sdram_req), 32'd0);
      check("mid_rst_wr", 32'(bus.sdram_wr), 32'd0);
      check("mid_rst_addr", 32'(bus.sdram_addr), 32'd0);
      check("mid_rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
    end
    // After reset the tie goes to read, from a zeroed pointer.
    run_burst(11'd800, 11'd300, 1'b0, 22'd0, 0, 1'b0);

    // Walk the read pointer to the last burst of the frame, then wrap.
    for (int k = 1; k < 1200; k++)
      run_burst(11'd100, 11'd0, 1'b0, 22'(k * 256), 0, 1'b0);
    run_burst(11'd100, 11'd0, 1'b0, 22'd0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
